// File: rtl/led_shift_sm.sv
// Serializes an MXLED-bit LED vector into an external shift-register chain
// with a divided shift clock, a latch strobe and periodic refresh.
module led_shift_sm #(
    parameter int MXLED  = 16,
    parameter int CLKDIV = 4,
    parameter int MXREF  = 19
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [MXLED-1:0] led_in,
    input  logic             blank,
    input  logic             test,
    output logic             led_sclk,
    output logic             led_sdata,
    output logic             led_latch,
    output logic             busy,
    output logic             frame_done
);
    localparam int             BCW      = $clog2(MXLED) + 1;
    localparam int             REFW     = MXREF + 1;
    localparam logic [7:0]     DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(MXLED - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REFW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [MXLED-1:0]  sr_q, sr_d;
    logic [MXLED-1:0]  last_sent_q, last_sent_d;
    logic              pending_q, pending_d;
    logic [MXLED-1:0]  led_in_q, led_in_d;
    logic              blank_q, blank_d;
    logic              test_q, test_d;
    logic              led_sclk_q, led_sclk_d;
    logic              led_sdata_q, led_sdata_d;
    logic              led_latch_q, led_latch_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [MXLED-1:0]  eff;
    logic              frame_due;

    always_comb begin
        led_in_d    = led_in;
        blank_d     = blank;
        test_d      = test;
        eff         = blank_q ? '0 : (test_q ? '1 : led_in_q);
        frame_due   = (eff != last_sent_q) || ref_cnt_q[MXREF] || pending_q;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ref_cnt_d   = ref_cnt_q;
        sr_d        = sr_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;

        case (state_q)
            IDLE: begin
                // Counter parks once the MSB sets, so a refresh stays due until serviced.
                if (!ref_cnt_q[MXREF]) ref_cnt_d = ref_cnt_q + REFW'(1);
                if (frame_due) state_d = LOAD;
            end
            LOAD: begin
                sr_d        = eff;
                last_sent_d = eff;
                pending_d   = 1'b0;
                bit_cnt_d   = '0;
                ref_cnt_d   = '0;
                state_d     = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_q == DIV_LAST) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    sr_d      = sr_q << 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    state_d   = (bit_cnt_q == BIT_LAST) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        div_d = ((state_d != state_q) || (div_q == DIV_LAST)) ? '0 : div_q + 8'(1);

        // Outputs are decoded from the current state and registered, one clock behind it.
        led_sclk_d   = (state_q == SHIFT_HI);
        led_sdata_d  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) ? sr_q[MXLED-1] : 1'b0;
        led_latch_d  = (state_q == LATCH);
        busy_d       = (state_q != IDLE);
        frame_done_d = (state_q == IDLE) && led_latch_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            sr_q         <= '0;
            last_sent_q  <= '0;
            pending_q    <= 1'b1;
            led_in_q     <= '0;
            blank_q      <= 1'b0;
            test_q       <= 1'b0;
            led_sclk_q   <= 1'b0;
            led_sdata_q  <= 1'b0;
            led_latch_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            sr_q         <= sr_d;
            last_sent_q  <= last_sent_d;
            pending_q    <= pending_d;
            led_in_q     <= led_in_d;
            blank_q      <= blank_d;
            test_q       <= test_d;
            led_sclk_q   <= led_sclk_d;
            led_sdata_q  <= led_sdata_d;
            led_latch_q  <= led_latch_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led_sclk   = led_sclk_q;
    assign led_sdata  = led_sdata_q;
    assign led_latch  = led_latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_shift_sm.sv
// Directed bench for led_shift_sm (MXLED=4, CLKDIV=2, MXREF=6) with a queue of
// expected frame payloads checked against the serial stream it observes.
module tb_led_shift_sm;
    localparam int MXLED     = 4;
    localparam int CLKDIV    = 2;
    localparam int MXREF     = 6;
    localparam int FRAME_LEN = 1 + 2 * MXLED * CLKDIV + CLKDIV;
    localparam int REF_GAP   = 1 << MXREF;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] led_in;
    logic       blank;
    logic       test;
    logic       led_sclk;
    logic       led_sdata;
    logic       led_latch;
    logic       busy;
    logic       frame_done;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] exp_q[$];

    int         frm_gap, frm_len, frm_rises, frm_latch;
    logic [3:0] frm_bits;
    logic       frm_ok, frm_done, frm_done2;

    led_shift_sm #(.MXLED(MXLED), .CLKDIV(CLKDIV), .MXREF(MXREF)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .led_in     (led_in),
        .blank      (blank),
        .test       (test),
        .led_sclk   (led_sclk),
        .led_sdata  (led_sdata),
        .led_latch  (led_latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    // Waits for busy, then records one frame cycle by cycle at falling edges.
    task automatic capture(input int chg_at, input logic [3:0] chg_val);
        logic prev, cur, ok;
        frm_gap = 0;
        while (!busy && frm_gap < 300) begin
            @(negedge clock);
            frm_gap++;
        end
        chk("busy_start", 32'(busy), 32'd1);
        frm_len = 0; frm_rises = 0; frm_latch = 0; frm_bits = '0;
        ok = 1'b1; prev = 1'b0; cur = 1'b0;
        while (busy && frm_len < 300) begin
            frm_len++;
            if (frm_len == chg_at) led_in = chg_val;
            if (led_sclk && !prev) begin
                frm_bits = {frm_bits[2:0], led_sdata};
                frm_rises++;
                cur = led_sdata;
            end else if (led_sclk && (led_sdata !== cur)) begin
                ok = 1'b0;
            end
            if (led_latch) begin
                frm_latch++;
                if (led_sclk || led_sdata) ok = 1'b0;
            end
            if (frame_done) ok = 1'b0;
            prev = led_sclk;
            @(negedge clock);
        end
        frm_ok   = ok;
        frm_done = frame_done;
        @(negedge clock);
        frm_done2 = frame_done;
    endtask

    task automatic check_frame(input string tag, input int exp_gap);
        logic [3:0] e;
        e = 4'bxxxx;
        chk({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_data"},  32'(frm_bits),  32'(e));
        chk({tag, "_len"},   32'(frm_len),   32'(FRAME_LEN));
        chk({tag, "_rises"}, 32'(frm_rises), 32'(MXLED));
        chk({tag, "_latch"}, 32'(frm_latch), 32'(CLKDIV));
        chk({tag, "_shape"}, 32'(frm_ok),    32'd1);
        chk({tag, "_done"},  32'(frm_done),  32'd1);
        chk({tag, "_done1"}, 32'(frm_done2), 32'd0);
        if (exp_gap >= 0) chk({tag, "_gap"}, 32'(frm_gap), 32'(exp_gap));
    endtask

    initial begin
        int w;
        reset_n = 1'b0; blank = 1'b0; test = 1'b0; led_in = 4'b0000;
        repeat (3) @(negedge clock);
        chk("rst_sclk",  32'(led_sclk),   32'd0);
        chk("rst_sdata", 32'(led_sdata),  32'd0);
        chk("rst_latch", 32'(led_latch),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);

        exp_q.push_back(4'b0000);
        reset_n = 1'b1;
        capture(0, 4'b0000);
        check_frame("post_reset", -1);

        led_in = 4'b1010;
        exp_q.push_back(4'b1010);
        capture(0, 4'b0000);
        check_frame("pat_1010", -1);

        led_in = 4'b0011;
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0110);
        capture(5, 4'b0110);
        check_frame("pre_toggle", -1);
        capture(0, 4'b0000);
        check_frame("post_toggle", 0);

        blank = 1'b1; test = 1'b1; led_in = 4'b1111;
        exp_q.push_back(4'b0000);
        capture(0, 4'b0000);
        check_frame("blank_test", -1);

        blank = 1'b0; led_in = 4'b0000;
        exp_q.push_back(4'b1111);
        capture(0, 4'b0000);
        check_frame("test_only", -1);

        test = 1'b0; led_in = 4'b1111;
        exp_q.push_back(4'b1111);
        capture(0, 4'b0000);
        check_frame("refresh1", REF_GAP);
        exp_q.push_back(4'b1111);
        capture(0, 4'b0000);
        check_frame("refresh2", REF_GAP);

        led_in = 4'b0101;
        w = 0;
        while (!led_sclk && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk("abort_sclk_seen", 32'(led_sclk), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_sclk",  32'(led_sclk),   32'd0);
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_latch", 32'(led_latch),  32'd0);
        chk("abort_done",  32'(frame_done), 32'd0);
        reset_n = 1'b1;
        exp_q.push_back(4'b0101);
        capture(0, 4'b0000);
        check_frame("post_abort", -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
